// File: rtl/rv_muldiv_arb_pkg.sv
// Shared types for the rv_muldiv scheduler: ALU codes, FSM states and op-class helpers.
package rv_muldiv_arb_pkg;

    typedef logic [3:0] alu_t;

    localparam alu_t ALU_DEFAULT = 4'h0;
    localparam alu_t ALU_MUL     = 4'h8;
    localparam alu_t ALU_MULH    = 4'h9;
    localparam alu_t ALU_MULHSU  = 4'hA;
    localparam alu_t ALU_MULHU   = 4'hB;
    localparam alu_t ALU_DIV     = 4'hC;
    localparam alu_t ALU_DIVU    = 4'hD;
    localparam alu_t ALU_REM     = 4'hE;
    localparam alu_t ALU_REMU    = 4'hF;

    localparam int DIV_TMO_MIN = 20;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV_ISSUE,
        DIV_WAIT,
        RESP
    } arb_state_t;

    function automatic logic is_div(alu_t alu);
        return (alu == ALU_DIV) || (alu == ALU_DIVU) || (alu == ALU_REM) || (alu == ALU_REMU);
    endfunction

    function automatic logic is_rem(alu_t alu);
        return (alu == ALU_REM) || (alu == ALU_REMU);
    endfunction

    function automatic logic is_mul(alu_t alu);
        return (alu == ALU_MUL) || (alu == ALU_MULH) || (alu == ALU_MULHSU) || (alu == ALU_MULHU);
    endfunction

endpackage

// File: rtl/rv_muldiv_arb_rr_arb2.sv
// Combinational two-way round-robin grant; the pointer register is owned by the parent.
module rv_muldiv_arb_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_rr_ptr,
    output logic [1:0] o_gnt
);

    // On contention the requester that was not granted last wins.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = i_rr_ptr ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/rv_muldiv_arb.sv
// Two-requester scheduler for rv_muldiv; MULDIV_DIV0_BYPASS_EN answers div-by-zero/overflow locally.
// States: IDLE accept | MUL capture product | DIV_ISSUE start divider | DIV_WAIT wait or time out | RESP hold response
module rv_muldiv_arb
    import rv_muldiv_arb_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int DIV_TMO = 40
) (
    input  logic                  i_clk,
    input  logic                  i_xreset,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  alu_t [1:0]            i_req_alu,
    input  logic [1:0][31:0]      i_req_a,
    input  logic [1:0][31:0]      i_req_b,
    input  logic [1:0][TAG_W-1:0] i_req_tag,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_data,
    output logic                  o_rsp_id,
    output logic [TAG_W-1:0]      o_rsp_tag,
    output logic                  o_rsp_err,
    output logic                  o_md_rdy,
    output alu_t                  o_md_alu,
    output logic [31:0]           o_md_rrd1,
    output logic [31:0]           o_md_rrd2,
    input  logic [31:0]           i_md_rwdat,
    input  logic                  i_md_cmpl
);

    // A timeout below the floor is raised to the floor instead of cutting the divider short.
    localparam int TMO_CYC = (DIV_TMO < DIV_TMO_MIN) ? DIV_TMO_MIN : DIV_TMO;
    localparam int TMO_W   = $clog2(TMO_CYC);

    arb_state_t       r_st;
    logic             r_rr_ptr;
    logic             r_byp;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_id;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_rsp_err;
    logic             r_md_rdy;
    alu_t             r_md_alu;
    logic [31:0]      r_md_rrd1;
    logic [31:0]      r_md_rrd2;
    logic [TMO_W-1:0] r_tmo;

    logic [1:0]       w_gnt;
    logic             w_sel;
    logic             w_accept;
    alu_t             w_alu;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    logic             w_byp;
    logic [31:0]      w_byp_data;

    rv_muldiv_arb_rr_arb2 u_rr_arb (
        .i_req    (i_req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_gnt)
    );

    assign w_sel       = w_gnt[1];
    assign w_accept    = (r_st == IDLE) && (w_gnt != 2'b00);
    assign w_alu       = i_req_alu[w_sel];
    assign w_a         = i_req_a[w_sel];
    assign w_b         = i_req_b[w_sel];
    assign o_req_ready = (r_st == IDLE) ? w_gnt : 2'b00;

`ifdef MULDIV_DIV0_BYPASS_EN
    logic w_b_zero;
    logic w_ovf;

    assign w_b_zero = (w_b == 32'd0);
    assign w_ovf    = ((w_alu == ALU_DIV) || (w_alu == ALU_REM)) &&
                      (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
    assign w_byp    = is_div(w_alu) && (w_b_zero || w_ovf);

    always_comb begin
        w_byp_data = 32'd0;
        if (w_b_zero) begin
            w_byp_data = is_rem(w_alu) ? w_a : 32'hFFFF_FFFF;
        end else if (w_ovf) begin
            w_byp_data = is_rem(w_alu) ? 32'd0 : 32'h8000_0000;
        end
    end
`else
    assign w_byp      = 1'b0;
    assign w_byp_data = 32'd0;
`endif

    always_ff @(posedge i_clk or posedge i_xreset) begin
        if (i_xreset) begin
            r_st        <= IDLE;
            r_rr_ptr    <= 1'b0;
            r_byp       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_id    <= 1'b0;
            r_rsp_tag   <= '0;
            r_rsp_err   <= 1'b0;
            r_md_rdy    <= 1'b0;
            r_md_alu    <= ALU_DEFAULT;
            r_md_rrd1   <= 32'd0;
            r_md_rrd2   <= 32'd0;
            r_tmo       <= '0;
        end else begin
            r_md_rdy <= 1'b0;
            case (r_st)
                IDLE: begin
                    if (w_accept) begin
                        r_rr_ptr  <= w_sel;
                        r_rsp_id  <= w_sel;
                        r_rsp_tag <= i_req_tag[w_sel];
                        r_rsp_err <= 1'b0;
                        r_md_alu  <= w_alu;
                        r_md_rrd1 <= w_a;
                        r_md_rrd2 <= w_b;
                        r_byp     <= w_byp;
                        // Bypassed divides reuse the MUL slot so they keep the two-cycle latency.
                        if (w_byp) begin
                            r_rsp_data <= w_byp_data;
                            r_st       <= MUL;
                        end else if (is_div(w_alu)) begin
                            r_md_rdy <= 1'b1;
                            r_st     <= DIV_ISSUE;
                        end else begin
                            r_st <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (!r_byp) begin
                        r_rsp_data <= i_md_rwdat;
                    end
                    r_rsp_valid <= 1'b1;
                    r_st        <= RESP;
                end
                DIV_ISSUE: begin
                    r_tmo <= TMO_W'(TMO_CYC - 1);
                    r_st  <= DIV_WAIT;
                end
                DIV_WAIT: begin
                    if (i_md_cmpl) begin
                        r_rsp_data  <= i_md_rwdat;
                        r_rsp_valid <= 1'b1;
                        r_st        <= RESP;
                    end else if (r_tmo == '0) begin
                        r_rsp_data  <= 32'd0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_st        <= RESP;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_st        <= IDLE;
                    end
                end
                default: r_st <= IDLE;
            endcase
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_tag   = r_rsp_tag;
    assign o_rsp_err   = r_rsp_err;
    assign o_md_rdy    = r_md_rdy;
    assign o_md_alu    = r_md_alu;
    assign o_md_rrd1   = r_md_rrd1;
    assign o_md_rrd2   = r_md_rrd2;

endmodule
